// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: source select, FSM states, load codes.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_PC4  = 2'b01,
        WB_LOAD = 2'b10,
        WB_MD   = 2'b11
    } wbsel_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WAIT_MD  = 2'b10
    } wb_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/half from a word and sign- or zero-extends it.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  logic [2:0]  fn3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data[7:0];
        unique case (addr)
            2'd0: byte_sel = data[7:0];
            2'd1: byte_sel = data[15:8];
            2'd2: byte_sel = data[23:16];
            2'd3: byte_sel = data[31:24];
        endcase
        half_sel = addr[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        result = data;
        case (fn3)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LBU:     result = {24'd0, byte_sel};
            LHU:     result = {16'd0, half_sel};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU/PC+4 results directly, waits for load or mul/div results.
// Define WB_INSTRET_EN to add a 64-bit retired-instruction counter on output instret.
module writeback_stage
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid5,
    input  logic        kill5,
    input  logic        we5,
    input  logic [4:0]  rd5,
    input  logic [1:0]  wbsel5,
    input  logic [2:0]  fn3_5,
    input  logic [31:0] alu_res5,
    input  logic [31:0] pc5,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        md_done,
    input  logic [31:0] md_result,
`ifdef WB_INSTRET_EN
    output logic [63:0] instret,
`endif
    output logic        stall_wb,
    output logic        we6,
    output logic [4:0]  rdaddr6,
    output logic [31:0] wb6
);

    wb_state_e   state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [2:0]  fn3_q, fn3_d;
    logic [1:0]  addr_q, addr_d;
    logic        we6_q, we6_d;
    logic [4:0]  rdaddr6_q, rdaddr6_d;
    logic [31:0] wb6_q, wb6_d;
    logic [31:0] load_res;
    logic        accept;

    load_align u_load_align (
        .data   (mem_rdata),
        .addr   (addr_q),
        .fn3    (fn3_q),
        .result (load_res)
    );

    assign stall_wb = (state_q != IDLE);
    assign accept   = valid5 && !kill5 && !stall_wb;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        we_d      = we_q;
        fn3_d     = fn3_q;
        addr_d    = addr_q;
        we6_d     = 1'b0;
        rdaddr6_d = rdaddr6_q;
        wb6_d     = wb6_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (wbsel_e'(wbsel5))
                        WB_ALU, WB_PC4: begin
                            if (we5 && rd5 != 5'd0) begin
                                we6_d     = 1'b1;
                                rdaddr6_d = rd5;
                                wb6_d     = (wbsel5 == WB_ALU) ? alu_res5 : pc5 + 32'd4;
                            end
                        end
                        WB_LOAD, WB_MD: begin
                            rd_d    = rd5;
                            we_d    = we5;
                            fn3_d   = fn3_5;
                            addr_d  = alu_res5[1:0];
                            state_d = (wbsel5 == WB_LOAD) ? WAIT_MEM : WAIT_MD;
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (we_q && rd_q != 5'd0) begin
                        we6_d     = 1'b1;
                        rdaddr6_d = rd_q;
                        wb6_d     = load_res;
                    end
                end
            end
            WAIT_MD: begin
                if (md_done) begin
                    state_d = IDLE;
                    if (we_q && rd_q != 5'd0) begin
                        we6_d     = 1'b1;
                        rdaddr6_d = rd_q;
                        wb6_d     = md_result;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_q      <= 5'd0;
            we_q      <= 1'b0;
            fn3_q     <= 3'd0;
            addr_q    <= 2'd0;
            we6_q     <= 1'b0;
            rdaddr6_q <= 5'd0;
            wb6_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            fn3_q     <= fn3_d;
            addr_q    <= addr_d;
            we6_q     <= we6_d;
            rdaddr6_q <= rdaddr6_d;
            wb6_q     <= wb6_d;
        end
    end

    assign we6     = we6_q;
    assign rdaddr6 = rdaddr6_q;
    assign wb6     = wb6_q;

`ifdef WB_INSTRET_EN
    // Counts every retirement, including ones whose register write is suppressed.
    logic        wb_event;
    logic [63:0] instret_q;

    assign wb_event = (state_q == IDLE && accept && !wbsel5[1]) ||
                      (state_q == WAIT_MEM && mem_rvalid) ||
                      (state_q == WAIT_MD && md_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= 64'd0;
        end else if (wb_event) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a writeback scoreboard.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid5, kill5, we5;
    logic [4:0]  rd5;
    logic [1:0]  wbsel5;
    logic [2:0]  fn3_5;
    logic [31:0] alu_res5, pc5;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        md_done;
    logic [31:0] md_result;
    logic        stall_wb, we6;
    logic [4:0]  rdaddr6;
    logic [31:0] wb6;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk        (clk),
        .rst        (rst),
        .valid5     (valid5),
        .kill5      (kill5),
        .we5        (we5),
        .rd5        (rd5),
        .wbsel5     (wbsel5),
        .fn3_5      (fn3_5),
        .alu_res5   (alu_res5),
        .pc5        (pc5),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .md_done    (md_done),
        .md_result  (md_result),
`ifdef WB_INSTRET_EN
        .instret    (instret),
`endif
        .stall_wb   (stall_wb),
        .we6        (we6),
        .rdaddr6    (rdaddr6),
        .wb6        (wb6)
    );

    // Scoreboard: every we6 pulse must match the oldest expected writeback.
    always @(negedge clk) begin
        if (we6) begin
            logic [36:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got rd=%0d data=%h, required no write", rdaddr6, wb6);
            end else begin
                e = exp_q.pop_front();
                if ({rdaddr6, wb6} !== e) begin
                    n_err++;
                    $display("FAIL sb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                             rdaddr6, wb6, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid5 = 0; kill5 = 0; we5 = 0; rd5 = 0; wbsel5 = 0; fn3_5 = 0;
        alu_res5 = 0; pc5 = 0; mem_rvalid = 0; mem_rdata = 0; md_done = 0; md_result = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        n_cmp += 4;
        if (stall_wb !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b required 0", stall_wb); end
        if (we6 !== 1'b0) begin n_err++; $display("FAIL rst_we6: got %b required 0", we6); end
        if (rdaddr6 !== 5'd0) begin n_err++; $display("FAIL rst_rdaddr: got %0d required 0", rdaddr6); end
        if (wb6 !== 32'd0) begin n_err++; $display("FAIL rst_wb6: got %h required 0", wb6); end
        rst = 0;
        step();
    endtask

    task automatic test_alu();
        valid5 = 1; we5 = 1; rd5 = 5; wbsel5 = 2'b00; alu_res5 = 32'h1234;
        exp_q.push_back({5'd5, 32'h1234});
        step();
        n_cmp += 3;
        if (we6 !== 1'b1) begin n_err++; $display("FAIL alu_we6: got %b required 1", we6); end
        if (rdaddr6 !== 5'd5) begin n_err++; $display("FAIL alu_rd: got %0d required 5", rdaddr6); end
        if (wb6 !== 32'h1234) begin n_err++; $display("FAIL alu_wb6: got %h required 1234", wb6); end
        clear_inputs();
        step();
        n_cmp += 2;
        if (we6 !== 1'b0) begin n_err++; $display("FAIL alu_pulse: got %b required 0", we6); end
        if (wb6 !== 32'h1234) begin n_err++; $display("FAIL alu_hold: got %h required 1234", wb6); end
    endtask

    task automatic test_jal_wrap();
        valid5 = 1; we5 = 1; rd5 = 1; wbsel5 = 2'b01; pc5 = 32'hFFFF_FFFC; alu_res5 = 32'hDEAD;
        exp_q.push_back({5'd1, 32'h0});
        step();
        n_cmp += 2;
        if (we6 !== 1'b1) begin n_err++; $display("FAIL jal_we6: got %b required 1", we6); end
        if (wb6 !== 32'h0) begin n_err++; $display("FAIL jal_wb6: got %h required 0", wb6); end
        clear_inputs();
        step();
    endtask

    task automatic test_load_stall();
        valid5 = 1; we5 = 1; rd5 = 7; wbsel5 = 2'b10; fn3_5 = 3'b000; alu_res5 = 32'h103;
        mem_rvalid = 1; mem_rdata = 32'h1111_1111;
        step();
        clear_inputs();
        n_cmp += 2;
        if (stall_wb !== 1'b1) begin n_err++; $display("FAIL ld_stall1: got %b required 1", stall_wb); end
        if (we6 !== 1'b0) begin n_err++; $display("FAIL ld_early: got %b required 0", we6); end
        step();
        n_cmp++;
        if (stall_wb !== 1'b1) begin n_err++; $display("FAIL ld_stall2: got %b required 1", stall_wb); end
        step();
        n_cmp++;
        if (stall_wb !== 1'b1) begin n_err++; $display("FAIL ld_stall3: got %b required 1", stall_wb); end
        mem_rvalid = 1; mem_rdata = 32'h80FF_0000;
        exp_q.push_back({5'd7, 32'hFFFF_FF80});
        step();
        clear_inputs();
        n_cmp += 4;
        if (we6 !== 1'b1) begin n_err++; $display("FAIL ld_we6: got %b required 1", we6); end
        if (rdaddr6 !== 5'd7) begin n_err++; $display("FAIL ld_rd: got %0d required 7", rdaddr6); end
        if (wb6 !== 32'hFFFF_FF80) begin n_err++; $display("FAIL ld_wb6: got %h required ffffff80", wb6); end
        if (stall_wb !== 1'b0) begin n_err++; $display("FAIL ld_unstall: got %b required 0", stall_wb); end
        step();
    endtask

    task automatic test_load_widths();
        logic [2:0]  fn3s [6] = '{3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b001};
        logic [1:0]  adrs [6] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0};
        logic [31:0] dats [6] = '{32'h8001_1234, 32'h0000_AB00, 32'h0000_F00F,
                                  32'hCAFE_BABE, 32'h1357_9BDF, 32'h0000_7FFF};
        logic [31:0] exps [6] = '{32'hFFFF_8001, 32'h0000_00AB, 32'h0000_F00F,
                                  32'hCAFE_BABE, 32'h1357_9BDF, 32'h0000_7FFF};
        for (int i = 0; i < 6; i++) begin
            valid5 = 1; we5 = 1; rd5 = 5'(10 + i); wbsel5 = 2'b10; fn3_5 = fn3s[i];
            alu_res5 = {30'h100, adrs[i]};
            step();
            clear_inputs();
            mem_rvalid = 1; mem_rdata = dats[i];
            exp_q.push_back({5'(10 + i), exps[i]});
            step();
            clear_inputs();
            n_cmp++;
            if (wb6 !== exps[i]) begin
                n_err++;
                $display("FAIL ldw_%0d: got %h required %h", i, wb6, exps[i]);
            end
        end
        step();
    endtask

    task automatic test_md_kill();
`ifdef WB_INSTRET_EN
        logic [63:0] base = instret;
`endif
        valid5 = 1; we5 = 1; rd5 = 0; wbsel5 = 2'b11; md_done = 1; md_result = 32'd99;
        step();
        clear_inputs();
        n_cmp++;
        if (stall_wb !== 1'b1) begin n_err++; $display("FAIL md_stall: got %b required 1", stall_wb); end
        valid5 = 1; kill5 = 1; we5 = 1; rd5 = 4; wbsel5 = 2'b00; alu_res5 = 32'h55;
        step();
        clear_inputs();
        n_cmp++;
        if (stall_wb !== 1'b1) begin n_err++; $display("FAIL md_killhold: got %b required 1", stall_wb); end
        md_done = 1; md_result = 32'd42;
        step();
        clear_inputs();
        n_cmp += 2;
        if (stall_wb !== 1'b0) begin n_err++; $display("FAIL md_idle: got %b required 0", stall_wb); end
        if (we6 !== 1'b0) begin n_err++; $display("FAIL md_rd0: got %b required 0", we6); end
`ifdef WB_INSTRET_EN
        n_cmp++;
        if (instret !== base + 64'd1) begin
            n_err++; $display("FAIL md_instret: got %0d required %0d", instret, base + 64'd1);
        end
`endif
        // Mul/div that does write
        valid5 = 1; we5 = 1; rd5 = 9; wbsel5 = 2'b11;
        step();
        clear_inputs();
        step();
        md_done = 1; md_result = 32'h0BAD_F00D;
        exp_q.push_back({5'd9, 32'h0BAD_F00D});
        step();
        clear_inputs();
        n_cmp++;
        if (wb6 !== 32'h0BAD_F00D) begin n_err++; $display("FAIL md_wb6: got %h required 0badf00d", wb6); end
        step();
    endtask

    task automatic test_reset_midwait();
        valid5 = 1; we5 = 1; rd5 = 12; wbsel5 = 2'b10; fn3_5 = 3'b010;
        step();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        step();
        clear_inputs();
        n_cmp += 3;
        if (we6 !== 1'b0) begin n_err++; $display("FAIL rmw_we6: got %b required 0", we6); end
        if (stall_wb !== 1'b0) begin n_err++; $display("FAIL rmw_stall: got %b required 0", stall_wb); end
        if (wb6 !== 32'h0) begin n_err++; $display("FAIL rmw_wb6: got %h required 0", wb6); end
`ifdef WB_INSTRET_EN
        n_cmp++;
        if (instret !== 64'd0) begin n_err++; $display("FAIL rmw_instret: got %0d required 0", instret); end
`endif
        step();
    endtask

    task automatic test_kill();
        valid5 = 1; kill5 = 1; we5 = 1; rd5 = 3; wbsel5 = 2'b00; alu_res5 = 32'hABCD;
        step();
        clear_inputs();
        n_cmp += 2;
        if (we6 !== 1'b0) begin n_err++; $display("FAIL kill_we6: got %b required 0", we6); end
        if (stall_wb !== 1'b0) begin n_err++; $display("FAIL kill_stall: got %b required 0", stall_wb); end
        // A killed load must not enter the wait state either
        valid5 = 1; kill5 = 1; we5 = 1; rd5 = 3; wbsel5 = 2'b10;
        step();
        clear_inputs();
        n_cmp++;
        if (stall_wb !== 1'b0) begin n_err++; $display("FAIL kill_ld: got %b required 0", stall_wb); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds  [6] = '{5'd2, 5'd3, 5'd0, 5'd4, 5'd6, 5'd31};
        logic        wes  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] vals [6];
        for (int i = 0; i < 6; i++) vals[i] = $urandom;
        for (int i = 0; i < 6; i++) begin
            valid5 = 1; we5 = wes[i]; rd5 = rds[i]; wbsel5 = 2'b00; alu_res5 = vals[i];
            if (wes[i] && rds[i] != 5'd0) exp_q.push_back({rds[i], vals[i]});
            step();
            n_cmp++;
            if (we6 !== (wes[i] && rds[i] != 5'd0)) begin
                n_err++;
                $display("FAIL b2b_we6_%0d: got %b required %b", i, we6, wes[i] && rds[i] != 5'd0);
            end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_alu();
        test_jal_wrap();
        test_load_stall();
        test_load_widths();
        test_md_kill();
        test_kill();
        test_back_to_back();
        test_reset_midwait();
        step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- valid5  in  1  execute stage presents an instruction
- kill5  in  1  squash the instruction presented this cycle
- we5  in  1  instruction writes rd
- rd5  in  5  destination register
- wbsel5  in  2  source select: 00 ALU, 01 PC+4, 10 load, 11 mul/div
- fn3_5  in  3  load width/sign code
- alu_res5  in  32  ALU result; also the load address
- pc5  in  32  instruction PC
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data word
- md_done  in  1  mul/div result valid
- md_result  in  32  mul/div result
- stall_wb  out  1  back-pressure to the issue and execute stages
- we6  out  1  register-file write enable
- rdaddr6  out  5  register-file write address
- wb6  out  32  register-file write data

Function
REQ-003 An instruction SHALL be accepted when valid5=1, kill5=0 and stall_wb=0; nothing else SHALL be accepted.
REQ-004 FSM states SHALL be IDLE, WAIT_MEM and WAIT_MD.
- IDLE and wbsel 10 accepted: go to WAIT_MEM.
- IDLE and wbsel 11 accepted: go to WAIT_MD.
- WAIT_MEM and mem_rvalid=1: go to IDLE.
- WAIT_MD and md_done=1: go to IDLE.
- Every other case: hold the current state.
REQ-005 stall_wb SHALL equal 1 combinationally in WAIT_MEM and WAIT_MD, and 0 in IDLE.
REQ-006 wbsel 00 SHALL write back alu_res5, and wbsel 01 SHALL write back pc5+4 (32-bit, wraps modulo 2^32). In both cases we6, rdaddr6 and wb6 SHALL update at the clock edge that accepts the instruction (latency 1).
REQ-007 For wbsel 10/11, the block SHALL latch rd5, we5, fn3_5 and alu_res5[1:0] at accept. Writeback SHALL occur at the edge on which mem_rvalid or md_done is sampled high in the wait state.
REQ-008 mem_rvalid and md_done SHALL be ignored outside their own wait state, including in the accept cycle.
REQ-009 Load extraction SHALL select the byte/half using the latched address bits and SHALL extend as follows:
- 000 LB: byte at addr[1:0], sign-extended
- 001 LH: half at addr[1], sign-extended
- 010 LW: full word
- 100 LBU: byte, zero-extended
- 101 LHU: half, zero-extended
- any other code: treated as LW
REQ-010 we6 SHALL be a single-cycle pulse, forced to 0 when the latched we=0 or rd=0. rdaddr6 and wb6 SHALL hold their last written values while we6=0.
REQ-011 kill5 SHALL affect only the instruction presented that cycle. An instruction already waiting in WAIT_MEM or WAIT_MD SHALL NOT be killed.
REQ-012 Back-to-back ALU instructions SHALL write back every cycle with no bubble.

Reset
REQ-013 While rst=1, the outputs SHALL be: state=IDLE, stall_wb=0, we6=0, rdaddr6=0, wb6=0. All latched fields SHALL be 0.
REQ-014 Reset asserted mid-wait SHALL abandon the pending instruction with no writeback. A mem_rvalid or md_done arriving after reset SHALL be ignored per REQ-008.

Configuration
REQ-015 When macro WB_INSTRET_EN is defined, the block SHALL add output instret [63:0].
- instret increments by 1 at each writeback event per REQ-006/REQ-007, including events with rd=0 or we=0.
- instret wraps modulo 2^64.
- instret resets to 0.
REQ-016 When WB_INSTRET_EN is undefined, the instret port and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-017 Package wb_pkg SHALL hold:
- the wbsel enum: WB_ALU, WB_PC4, WB_LOAD, WB_MD;
- the FSM state enum;
- the fn3 load codes: LB, LH, LW, LBU, LHU.
REQ-018 Load extraction SHALL be the sub-module load_align: inputs data[31:0], addr[1:0], fn3[2:0]; output result[31:0]; purely combinational.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ALU: valid5=1, wbsel=00, we5=1, rd5=5, alu_res5=0x1234 -> next edge we6=1, rdaddr6=5, wb6=0x1234; following cycle we6=0.
- Jump link wrap: wbsel=01, pc5=0xFFFFFFFC, rd5=1 -> wb6=0x00000000, we6=1.
- Load stall: wbsel=10, fn3=000, alu_res5=0x103, rd5=7 -> stall_wb=1 for 3 cycles. mem_rvalid is pulsed in the accept cycle (ignored), then mem_rdata=0x80FF0000 is presented with mem_rvalid=1 two cycles later -> wb6=0xFFFFFF80, rdaddr6=7, stall_wb=0 after.
- Mul/div with kill: wbsel=11, rd5=0, we5=1; kill5 pulsed while in WAIT_MD; md_done with md_result=42 -> state returns to IDLE, we6 stays 0 (rd=0). With WB_INSTRET_EN, instret increments by 1.
- Reset mid-wait: in WAIT_MEM assert rst for 1 cycle, then pulse mem_rvalid -> no we6 pulse, stall_wb=0, wb6=0, instret=0.
- Kill: valid5=1, kill5=1, wbsel=00, rd5=3 -> no we6 pulse, state stays IDLE.
